// File: rtl/memwr_arbiter.sv
// Single-owner arbiter for the playfield colour-write port: two handshaked streams
// (border init, row shift) plus a self-sequenced 4-cell piece-lock burst.
module memwr_arbiter #(
    parameter int BLOCKS_VERTICAL   = 12,
    parameter int BLOCKS_HORIZONTAL = 21,
    parameter int COORD_W           = 5,
    parameter int COLOR_W           = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init_valid,
    input  logic               init_last,
    input  logic [COORD_W-1:0] init_x,
    input  logic [COORD_W-1:0] init_y,
    input  logic [COLOR_W-1:0] init_color,
    output logic               init_ready,
    input  logic               shift_valid,
    input  logic               shift_last,
    input  logic [COORD_W-1:0] shift_x,
    input  logic [COORD_W-1:0] shift_y,
    input  logic [COLOR_W-1:0] shift_color,
    output logic               shift_ready,
    input  logic               lock_req,
    input  logic [COORD_W-1:0] lock_x0,
    input  logic [COORD_W-1:0] lock_x1,
    input  logic [COORD_W-1:0] lock_x2,
    input  logic [COORD_W-1:0] lock_x3,
    input  logic [COORD_W-1:0] lock_y0,
    input  logic [COORD_W-1:0] lock_y1,
    input  logic [COORD_W-1:0] lock_y2,
    input  logic [COORD_W-1:0] lock_y3,
    input  logic [COLOR_W-1:0] lock_color,
    output logic               lock_done,
    output logic               wr_en,
    output logic [COORD_W-1:0] wr_x,
    output logic [COORD_W-1:0] wr_y,
    output logic [COLOR_W-1:0] wr_color,
    output logic               mem_busy,
    output logic               range_err
);
    localparam logic [COORD_W-1:0] MAX_X = COORD_W'(BLOCKS_VERTICAL);
    localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(BLOCKS_HORIZONTAL);

    typedef enum logic [2:0] {IDLE, INIT, SHIFT, LOCK, DONE} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         cnt_reg;
    logic [COORD_W-1:0] cell_x_reg [4];
    logic [COORD_W-1:0] cell_y_reg [4];
    logic [COLOR_W-1:0] lock_color_reg;
    logic [COORD_W-1:0] lock_x_in  [4];
    logic [COORD_W-1:0] lock_y_in  [4];

    logic               beat_fire;
    logic               beat_in_range;
    logic               lock_grant;
    logic [COORD_W-1:0] beat_x, beat_y;
    logic [COLOR_W-1:0] beat_color;

    assign lock_x_in[0] = lock_x0;
    assign lock_x_in[1] = lock_x1;
    assign lock_x_in[2] = lock_x2;
    assign lock_x_in[3] = lock_x3;
    assign lock_y_in[0] = lock_y0;
    assign lock_y_in[1] = lock_y1;
    assign lock_y_in[2] = lock_y2;
    assign lock_y_in[3] = lock_y3;

    // Grant priority is only evaluated in IDLE, which makes ownership non-preemptive.
    always_comb begin
        state_next = state_reg;
        beat_fire  = 1'b0;
        beat_x     = init_x;
        beat_y     = init_y;
        beat_color = init_color;
        case (state_reg)
            IDLE: begin
                if (init_valid)       state_next = INIT;
                else if (shift_valid) state_next = SHIFT;
                else if (lock_req)    state_next = LOCK;
            end
            INIT: begin
                beat_fire = init_valid;
                if (init_valid && init_last) state_next = IDLE;
            end
            SHIFT: begin
                beat_fire  = shift_valid;
                beat_x     = shift_x;
                beat_y     = shift_y;
                beat_color = shift_color;
                if (shift_valid && shift_last) state_next = IDLE;
            end
            LOCK: begin
                beat_fire  = 1'b1;
                beat_x     = cell_x_reg[cnt_reg];
                beat_y     = cell_y_reg[cnt_reg];
                beat_color = lock_color_reg;
                if (cnt_reg == 2'd3) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign beat_in_range = (beat_x < MAX_X) && (beat_y < MAX_Y);
    assign lock_grant    = (state_reg == IDLE) && (state_next == LOCK);

    assign init_ready  = (state_reg == INIT);
    assign shift_ready = (state_reg == SHIFT);
    assign lock_done   = (state_reg == DONE);
    assign mem_busy    = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            wr_en          <= 1'b0;
            range_err      <= 1'b0;
            wr_x           <= '0;
            wr_y           <= '0;
            wr_color       <= '0;
            lock_color_reg <= '0;
            for (int i = 0; i < 4; i++) begin
                cell_x_reg[i] <= '0;
                cell_y_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            wr_en     <= beat_fire && beat_in_range;
            range_err <= beat_fire && !beat_in_range;
            // Suppressed beats leave the write bus untouched so it always shows the last real write.
            if (beat_fire && beat_in_range) begin
                wr_x     <= beat_x;
                wr_y     <= beat_y;
                wr_color <= beat_color;
            end
            if (lock_grant) begin
                cnt_reg        <= '0;
                lock_color_reg <= lock_color;
                for (int i = 0; i < 4; i++) begin
                    cell_x_reg[i] <= lock_x_in[i];
                    cell_y_reg[i] <= lock_y_in[i];
                end
            end else if (state_reg == LOCK) begin
                cnt_reg <= cnt_reg + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_memwr_arbiter.sv
// Scoreboard bench for memwr_arbiter: drivers push predicted writes, a negedge monitor checks them.
module tb_memwr_arbiter;
    typedef struct packed {logic [4:0] x; logic [4:0] y; logic [2:0] c;} beat_t;
    typedef struct packed {logic err; logic [4:0] x; logic [4:0] y; logic [2:0] c;} exp_t;

    logic clk = 1'b0, reset = 1'b0;
    logic init_valid = 1'b0, init_last = 1'b0;
    logic [4:0] init_x = '0, init_y = '0;
    logic [2:0] init_color = '0;
    logic shift_valid = 1'b0, shift_last = 1'b0;
    logic [4:0] shift_x = '0, shift_y = '0;
    logic [2:0] shift_color = '0;
    logic lock_req = 1'b0;
    logic [4:0] lock_x0 = '0, lock_x1 = '0, lock_x2 = '0, lock_x3 = '0;
    logic [4:0] lock_y0 = '0, lock_y1 = '0, lock_y2 = '0, lock_y3 = '0;
    logic [2:0] lock_color = '0;
    logic init_ready, shift_ready, lock_done, wr_en, mem_busy, range_err;
    logic [4:0] wr_x, wr_y;
    logic [2:0] wr_color;

    memwr_arbiter dut (
        .clk(clk), .reset(reset),
        .init_valid(init_valid), .init_last(init_last), .init_x(init_x), .init_y(init_y),
        .init_color(init_color), .init_ready(init_ready),
        .shift_valid(shift_valid), .shift_last(shift_last), .shift_x(shift_x), .shift_y(shift_y),
        .shift_color(shift_color), .shift_ready(shift_ready),
        .lock_req(lock_req), .lock_x0(lock_x0), .lock_x1(lock_x1), .lock_x2(lock_x2), .lock_x3(lock_x3),
        .lock_y0(lock_y0), .lock_y1(lock_y1), .lock_y2(lock_y2), .lock_y3(lock_y3),
        .lock_color(lock_color), .lock_done(lock_done),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .mem_busy(mem_busy), .range_err(range_err)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    logic  rst_edge;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= reset;
    end

    int    n_cmp = 0, n_fail = 0, done_cnt = 0;
    exp_t  exp_q[$];
    int    acc_q[$];
    beat_t init_q[$], shift_q[$];
    beat_t lock_cells[4];
    logic [2:0] lock_col;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_msg(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
    endtask

    // Reference rule: a beat is written iff x < 12 and y < 21, coordinates pass unchanged.
    function automatic exp_t predict(input logic [4:0] x, input logic [4:0] y, input logic [2:0] c);
        predict = '{err: !((x < 5'd12) && (y < 5'd21)), x: x, y: y, c: c};
    endfunction

    function automatic beat_t rand_beat();
        rand_beat = '{x: 5'($urandom_range(0, 14)), y: 5'($urandom_range(0, 23)), c: 3'($urandom)};
    endfunction

    // Monitor: every output event is matched against the head of the scoreboard.
    initial begin
        exp_t e;
        logic [12:0] last_w = '0;
        forever begin
            @(negedge clk);
            if (rst_edge === 1'b0) begin
                check("reset_outputs", 32'({wr_en, range_err, lock_done, init_ready, shift_ready,
                                            mem_busy, wr_x, wr_y, wr_color}), 32'd0);
                last_w = '0;
            end else begin
                if (lock_done) done_cnt++;
                if (wr_en || range_err) begin
                    if (exp_q.size() == 0) begin
                        fail_msg("unexpected_write");
                    end else begin
                        e = exp_q.pop_front();
                        check("range_err", 32'(range_err), 32'(e.err));
                        check("wr_en", 32'(wr_en), 32'(!e.err));
                        if (!e.err) begin
                            check("wr_data", 32'({wr_x, wr_y, wr_color}), 32'({e.x, e.y, e.c}));
                            last_w = {e.x, e.y, e.c};
                        end
                    end
                end
                if (!wr_en) check("wr_hold", 32'({wr_x, wr_y, wr_color}), 32'(last_w));
                while (acc_q.size() > 0 && acc_q[0] < cyc) begin
                    void'(acc_q.pop_front());
                    fail_msg("accept_latency_missed");
                end
                if (acc_q.size() > 0 && acc_q[0] == cyc) begin
                    void'(acc_q.pop_front());
                    check("accept_to_write", 32'(wr_en || range_err), 32'd1);
                end
            end
        end
    end

    task automatic set_src(input bit sel, input logic v, input beat_t b, input logic l);
        if (sel) begin
            shift_valid = v; shift_x = b.x; shift_y = b.y; shift_color = b.c; shift_last = l;
        end else begin
            init_valid = v; init_x = b.x; init_y = b.y; init_color = b.c; init_last = l;
        end
    endtask

    // Called on a negedge; returns on the negedge after the last beat was accepted.
    task automatic drive_stream(input bit sel, input bit gaps);
        int n, gap, waited;
        bit rdy;
        beat_t b;
        n = sel ? shift_q.size() : init_q.size();
        for (int i = 0; i < n; i++) begin
            b = sel ? shift_q[i] : init_q[i];
            gap = (gaps && i > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            for (int g = 0; g < gap; g++) begin
                set_src(sel, 1'b0, b, 1'b0);
                @(negedge clk);
            end
            set_src(sel, 1'b1, b, 1'(i == n - 1));
            waited = 0;
            rdy = sel ? shift_ready : init_ready;
            while (!rdy && waited < 2000) begin
                @(negedge clk);
                waited++;
                rdy = sel ? shift_ready : init_ready;
            end
            if (!rdy) begin
                fail_msg(sel ? "shift_grant_timeout" : "init_grant_timeout");
                set_src(sel, 1'b0, '0, 1'b0);
                return;
            end
            acc_q.push_back(cyc + 1);
            @(negedge clk);
        end
        set_src(sel, 1'b0, '0, 1'b0);
        check(sel ? "shift_ready_drop" : "init_ready_drop", 32'(sel ? shift_ready : init_ready), 32'd0);
    endtask

    task automatic apply_lock_inputs();
        lock_x0 = lock_cells[0].x; lock_x1 = lock_cells[1].x; lock_x2 = lock_cells[2].x; lock_x3 = lock_cells[3].x;
        lock_y0 = lock_cells[0].y; lock_y1 = lock_cells[1].y; lock_y2 = lock_cells[2].y; lock_y3 = lock_cells[3].y;
        lock_color = lock_col;
    endtask

    task automatic scramble_lock_inputs();
        lock_x0 = 5'($urandom); lock_x1 = 5'($urandom); lock_x2 = 5'($urandom); lock_x3 = 5'($urandom);
        lock_y0 = 5'($urandom); lock_y1 = 5'($urandom); lock_y2 = 5'($urandom); lock_y3 = 5'($urandom);
        lock_color = 3'($urandom);
    endtask

    task automatic drive_lock();
        int waited = 0;
        apply_lock_inputs();
        lock_req = 1'b1;
        @(negedge clk);
        while (!lock_done && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!lock_done) fail_msg("lock_done_timeout");
        lock_req = 1'b0;
        scramble_lock_inputs();
    endtask

    // Model: all selected requesters start together; writes come out in priority order.
    task automatic run_mixed(input logic [2:0] mask, input bit gaps);
        int d0 = done_cnt;
        if (mask[0]) foreach (init_q[i]) exp_q.push_back(predict(init_q[i].x, init_q[i].y, init_q[i].c));
        if (mask[1]) foreach (shift_q[i]) exp_q.push_back(predict(shift_q[i].x, shift_q[i].y, shift_q[i].c));
        if (mask[2]) for (int k = 0; k < 4; k++) exp_q.push_back(predict(lock_cells[k].x, lock_cells[k].y, lock_col));
        fork
            begin if (mask[0]) drive_stream(1'b0, gaps); end
            begin if (mask[1]) drive_stream(1'b1, gaps); end
            begin if (mask[2]) drive_lock(); end
        join
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("lock_done_count", 32'(done_cnt - d0), 32'(mask[2]));
    endtask

    initial begin
        int t0, d0;
        logic [2:0] mask;
        // Test 1: reset for 3 cycles, then idle.
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle_outputs", 32'({wr_en, range_err, lock_done, init_ready, shift_ready,
                                       mem_busy, wr_x, wr_y, wr_color}), 32'd0);
        end

        // Test 2: 54-beat init stream, valid every cycle, corners (0,0) and (11,20).
        init_q.delete();
        for (int i = 0; i < 54; i++)
            init_q.push_back('{x: 5'($urandom_range(0, 11)), y: 5'($urandom_range(0, 20)), c: 3'b110});
        init_q[0]  = '{x: 5'd0,  y: 5'd0,  c: 3'b110};
        init_q[53] = '{x: 5'd11, y: 5'd20, c: 3'b110};
        foreach (init_q[i]) exp_q.push_back(predict(init_q[i].x, init_q[i].y, init_q[i].c));
        t0 = cyc;
        drive_stream(1'b0, 1'b0);
        check("init_stream_cycles", 32'(cyc - t0), 32'd55);
        repeat (2) @(negedge clk);

        // Test 3: lock burst with exact timing; request dropped one cycle after grant.
        lock_cells = '{'{5'd4, 5'd1, 3'd0}, '{5'd5, 5'd1, 3'd0}, '{5'd4, 5'd2, 3'd0}, '{5'd5, 5'd2, 3'd0}};
        lock_col = 3'b010;
        for (int k = 0; k < 4; k++) exp_q.push_back(predict(lock_cells[k].x, lock_cells[k].y, lock_col));
        d0 = done_cnt;
        apply_lock_inputs();
        lock_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("lock_wr_en_timing", 32'(wr_en), 32'(k >= 2 && k <= 5));
            check("lock_done_timing", 32'(lock_done), 32'(k == 5));
            check("lock_busy_timing", 32'(mem_busy), 32'(k <= 5));
            if (k == 2) begin
                lock_req = 1'b0;
                scramble_lock_inputs();
            end
        end
        check("lock_done_once", 32'(done_cnt - d0), 32'd1);
        check("lock_drained", 32'(exp_q.size()), 32'd0);

        // Test 4: all three requesters at once.
        init_q.delete(); shift_q.delete();
        repeat (5) init_q.push_back(rand_beat());
        repeat (4) shift_q.push_back(rand_beat());
        foreach (lock_cells[k]) lock_cells[k] = rand_beat();
        lock_col = 3'($urandom);
        run_mixed(3'b111, 1'b0);

        // Test 5: out-of-range lock cell and shift beat.
        init_q.delete(); shift_q.delete();
        shift_q.push_back('{5'd2, 5'd2, 3'd1});
        shift_q.push_back('{5'd5, 5'd21, 3'd4});
        shift_q.push_back('{5'd11, 5'd20, 3'd7});
        lock_cells = '{'{5'd12, 5'd3, 3'd0}, '{5'd1, 5'd1, 3'd0}, '{5'd11, 5'd20, 3'd0}, '{5'd0, 5'd0, 3'd0}};
        lock_col = 3'd5;
        run_mixed(3'b110, 1'b0);

        // Randomized mixes with valid gaps.
        for (int it = 0; it < 25; it++) begin
            init_q.delete(); shift_q.delete();
            mask = 3'($urandom_range(1, 7));
            repeat ($urandom_range(1, 6)) init_q.push_back(rand_beat());
            repeat ($urandom_range(1, 6)) shift_q.push_back(rand_beat());
            foreach (lock_cells[k]) lock_cells[k] = rand_beat();
            lock_col = 3'($urandom);
            run_mixed(mask, 1'b1);
        end

        // Test 6: reset during LOCK beat 2 abandons the burst.
        lock_cells = '{'{5'd1, 5'd2, 3'd0}, '{5'd3, 5'd4, 3'd0}, '{5'd5, 5'd6, 3'd0}, '{5'd7, 5'd8, 3'd0}};
        lock_col = 3'd5;
        exp_q.push_back(predict(5'd1, 5'd2, 3'd5));
        exp_q.push_back(predict(5'd3, 5'd4, 3'd5));
        d0 = done_cnt;
        apply_lock_inputs();
        lock_req = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lock_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_reset_busy", 32'(mem_busy), 32'd0);
        end
        check("reset_no_lock_done", 32'(done_cnt - d0), 32'd0);
        check("reset_writes_before", 32'(exp_q.size()), 32'd0);

        repeat (3) @(negedge clk);
        check("final_accepts_drained", 32'(acc_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/memwr_arbiter.md
Name: memwr_arbiter

Overview:
Owns the single colour-write port of the playfield memory and shares it between three requesters.
- Border painter (init stream).
- Row-shift engine (shift stream).
- Piece-lock logic, a 4-cell burst that the arbiter sequences itself.

It sits between blkmemory's control logic and memory's color_set_requestor_x/y, color_setter and color_commit inputs. It guarantees one owner at a time, non-preemptive grants and deterministic one-cycle write latency.

Parameters:
BLOCKS_VERTICAL, 12, number of valid x coordinates (0..11); writes with x >= this are suppressed.
BLOCKS_HORIZONTAL, 21, number of valid y coordinates (0..20); writes with y >= this are suppressed.
COORD_W, 5, width of every coordinate bus.
COLOR_W, 3, width of every colour bus.

Ports:
clk  in  1  system clock; all state is on its rising edge.
reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
init_valid / init_last  in  1 / 1  border-painter beat valid; last beat of stream.
init_x / init_y / init_color  in  COORD_W / COORD_W / COLOR_W  border-painter beat payload.
init_ready  out  1  high while the init requester owns the port.
shift_valid / shift_last  in  1 / 1  row-shift beat valid; last beat of stream.
shift_x / shift_y / shift_color  in  COORD_W / COORD_W / COLOR_W  row-shift beat payload.
shift_ready  out  1  high while the shift requester owns the port.
lock_req  in  1  level; request a 4-cell lock burst.
lock_x0..lock_x3 / lock_y0..lock_y3  in  COORD_W each  the four piece cells.
lock_color  in  COLOR_W  colour of the locked piece.
lock_done  out  1  one-cycle pulse when the burst has been issued.
wr_en  out  1  to memory color_commit.
wr_x / wr_y / wr_color  out  COORD_W / COORD_W / COLOR_W  to memory setter inputs.
mem_busy  out  1  high whenever state != IDLE.
range_err  out  1  one-cycle pulse for each suppressed out-of-range beat.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - wr_en, lock_done, range_err, init_ready, shift_ready and mem_busy are 0.
  - wr_x, wr_y, wr_color, the beat counter and the latched lock cells are 0.
  - Reset mid-operation abandons the burst or stream immediately; no completion pulse is produced.
- States: IDLE, INIT, SHIFT, LOCK, DONE.
- Grant arbitration (IDLE only): fixed priority init_valid > shift_valid > lock_req.
  - A grant is evaluated every IDLE cycle and enters the chosen state on the next edge.
  - If nothing is requested, remain in IDLE.
- Grants are non-preemptive: a higher-priority request arriving while another owner holds the port waits until the state returns to IDLE.
- Stream states (INIT, SHIFT):
  - ready is asserted combinationally from the state.
  - A beat is accepted on each cycle where valid && ready.
  - The accepted payload appears on wr_x/wr_y/wr_color with wr_en=1 on the following cycle (1-cycle latency, registered outputs).
  - valid low without a prior last: ownership is held, wr_en is 0 in the following cycle, and no timeout applies.
  - An accepted beat with last=1 returns the state to IDLE on the next edge; ready drops in that same next cycle.
- LOCK:
  - On entry, lock_x0..3, lock_y0..3 and lock_color are latched.
  - Beat counter runs 0..3. Beat i drives cell i with wr_en=1 on the cycle after the counter reads i, so there are exactly 4 consecutive wr_en cycles.
  - After beat 3 the state goes to DONE.
  - lock_req deasserted mid-burst is ignored; the burst completes from the latched copy.
- DONE:
  - lock_done=1 for exactly one cycle, then IDLE.
  - If lock_req is still high in IDLE, a new burst is granted (requester must drop lock_req on lock_done).
- Range check applies to every beat from any source:
  - Out of range means x >= BLOCKS_VERTICAL or y >= BLOCKS_HORIZONTAL.
  - On that beat's output cycle, wr_en is forced to 0 and range_err pulses. The counter and stream still advance.
- Coordinate arithmetic: no arithmetic is performed on coordinates; they are passed through unmodified.
- wr_x/wr_y/wr_color hold their last value whenever wr_en=0.
- Simultaneous init_valid and lock_req in IDLE: INIT is granted; LOCK is granted in the first IDLE cycle after INIT ends, if shift_valid is low.
- Minimum gaps:
  - LOCK turnaround is grant (1) + 4 writes + DONE (1).
  - Back-to-back grants are separated by at least one IDLE cycle.

Test Plan:
1. Reset held for 3 cycles, then released with no requests -> all outputs 0 and mem_busy=0 for 10 cycles.
2. Init stream of 54 beats, cells (0,0)..(11,20), colour 3'b110, last on beat 54, valid every cycle -> 54 consecutive wr_en cycles, each one cycle after acceptance; init_ready falls one cycle after the last beat.
3. lock_req with cells (4,1),(5,1),(4,2),(5,2), colour 3'b010, lock_req dropped 1 cycle after grant -> 4 wr_en cycles in cell order, then lock_done pulse, then IDLE.
4. init_valid, shift_valid and lock_req asserted in the same cycle -> INIT, then SHIFT, then LOCK, each separated by one IDLE cycle; no wr_en overlap; lock_done once.
5. Lock cell (12,3) and a shift beat at y=21 -> wr_en suppressed on those beats, a range_err pulse for each, other beats written normally, lock_done still pulses.
6. reset pulsed low during LOCK beat 2 -> wr_en=0 next cycle, no lock_done, IDLE, latched cells cleared.
